// File: rtl/selector_pkg.sv
// Shared types for the selector arbiter: FSM state encoding and the
// channel-index width helper.
package selector_pkg;

    typedef enum logic {
        VACIO = 1'b0,
        LLENO = 1'b1
    } estado_t;

    // Width of a channel index, never narrower than one bit.
    function automatic int cw_of(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/arbitro_sel.sv
// Channel arbiter: picks one requesting channel, returning one-hot grant and index.
// Round-robin when SELECTOR_ARB_RR_EN is defined, fixed priority (lowest index) otherwise.
module arbitro_sel #(
    parameter int NUM_ENT = 5,
    parameter int CW      = 3
) (
    input  logic [NUM_ENT-1:0] sel,
    input  logic [CW-1:0]      ult,
    input  logic               enable,
    output logic [NUM_ENT-1:0] gnt,
    output logic [CW-1:0]      idx
);

    logic found;

`ifdef SELECTOR_ARB_RR_EN
    int c;

    // Search starts one past the last granted channel and wraps.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int i = 1; i <= NUM_ENT; i++) begin
            c = (int'(ult) + i) % NUM_ENT;
            if (enable && !found && sel[CW'(c)]) begin
                found          = 1'b1;
                gnt[CW'(c)]    = 1'b1;
                idx            = CW'(c);
            end
        end
    end
`else
    logic unused_ult;
    assign unused_ult = ^ult;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_ENT; k++) begin
            if (enable && !found && sel[CW'(k)]) begin
                found       = 1'b1;
                gnt[CW'(k)] = 1'b1;
                idx         = CW'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/selector_arb.sv
// N-to-1 selector with a single output register and ready/valid handshake.
// Define SELECTOR_ARB_RR_EN for round-robin arbitration (default: fixed priority).
//
// state | meaning
// VACIO | output register empty, sal_valida=0
// LLENO | output register holds an untransferred word, sal_valida=1
module selector_arb
    import selector_pkg::*;
#(
    parameter int tamData = 7,
    parameter int NUM_ENT = 5
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_ENT*(tamData+1)-1:0]   ent,
    input  logic [NUM_ENT-1:0]               sel,
    input  logic                             listo_sal,
    output logic [tamData:0]                 sal,
    output logic                             sal_valida,
    output logic [cw_of(NUM_ENT)-1:0]        canal,
    output logic [NUM_ENT-1:0]               ack
);

    localparam int CW = cw_of(NUM_ENT);
    localparam int W  = tamData + 1;

    estado_t          estado;
    estado_t          estado_sig;
    logic             load;
    logic [NUM_ENT-1:0] gnt;
    logic [CW-1:0]    idx;
    logic [CW-1:0]    ult;
    logic [tamData:0] palabra;

    // A slot opens either when empty or when the held word leaves this cycle.
    assign load = !reset && (|sel) && ((estado == VACIO) || listo_sal);

    arbitro_sel #(
        .NUM_ENT (NUM_ENT),
        .CW      (CW)
    ) u_arbitro (
        .sel    (sel),
        .ult    (ult),
        .enable (load),
        .gnt    (gnt),
        .idx    (idx)
    );

    assign ack = gnt;

`ifdef SELECTOR_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ult <= CW'(NUM_ENT - 1);
        end else if (load) begin
            ult <= idx;
        end
    end
`else
    assign ult = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            estado <= VACIO;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig = estado;
        if (load) begin
            estado_sig = LLENO;
        end else if ((estado == LLENO) && listo_sal) begin
            estado_sig = VACIO;
        end
    end

    assign sal_valida = (estado == LLENO);

    // Grant is one-hot, so an OR of masked channels is the selected word.
    always_comb begin
        palabra = '0;
        for (int k = 0; k < NUM_ENT; k++) begin
            if (gnt[CW'(k)]) begin
                palabra = palabra | ent[k*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sal   <= '0;
            canal <= '0;
        end else if (load) begin
            sal   <= palabra;
            canal <= idx;
        end
    end

endmodule

// File: tb/tb_selector_arb.sv
// Self-checking bench for selector_arb (default parameters), directed steps
// followed by random traffic compared against a cycle-level reference model.
module tb_selector_arb;

    logic        clk;
    logic        reset;
    logic [39:0] ent;
    logic [4:0]  sel;
    logic        listo_sal;
    logic [7:0]  sal;
    logic        sal_valida;
    logic [2:0]  canal;
    logic [4:0]  ack;

    int total;
    int bad;

    // reference model state
    logic       m_valid;
    logic [7:0] m_sal;
    int         m_canal;
    int         m_ult;

    selector_arb dut (
        .clk        (clk),
        .reset      (reset),
        .ent        (ent),
        .sel        (sel),
        .listo_sal  (listo_sal),
        .sal        (sal),
        .sal_valida (sal_valida),
        .canal      (canal),
        .ack        (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(input logic [4:0] s, input int u);
`ifdef SELECTOR_ARB_RR_EN
        for (int i = 1; i <= 5; i++) begin
            if (s[(u + i) % 5]) return (u + i) % 5;
        end
`else
        for (int i = 0; i < 5; i++) begin
            if (s[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive, check ack before the edge, check registers after it.
    task automatic cycle(input logic r, input logic [4:0] s, input logic [39:0] e, input logic l);
        logic ld;
        int   w;
        logic [4:0] exp_ack;
        reset = r; sel = s; ent = e; listo_sal = l;
        #1;
        ld = !r && (s != 5'b0) && (!m_valid || l);
        w  = ld ? pick(s, m_ult) : -1;
        exp_ack = ld ? (5'b1 << w) : 5'b0;
        chk("ack", int'(ack), int'(exp_ack));
        @(posedge clk);
        #1;
        if (r) begin
            m_valid = 1'b0; m_sal = 8'h00; m_canal = 0; m_ult = 4;
        end else if (ld) begin
            m_valid = 1'b1; m_sal = e[w*8 +: 8]; m_canal = w; m_ult = w;
        end else if (m_valid && l) begin
            m_valid = 1'b0;
        end
        chk("sal_valida", int'(sal_valida), int'(m_valid));
        chk("sal", int'(sal), int'(m_sal));
        chk("canal", int'(canal), m_canal);
    endtask

    initial begin
        logic [39:0] e;
        int rr_exp [6];
        total = 0; bad = 0;
        m_valid = 1'b0; m_sal = 8'h00; m_canal = 0; m_ult = 4;
        e = 40'h44_33_22_11_00;

        // reset with every channel requesting
        cycle(1'b1, 5'b11111, e, 1'b1);
        cycle(1'b1, 5'b11111, e, 1'b1);
        chk("rst_sal", int'(sal), 0);
        chk("rst_valid", int'(sal_valida), 0);

        // single request on channel 2
        e[16 +: 8] = 8'hA5;
        cycle(1'b0, 5'b00100, e, 1'b1);
        chk("single_sal", int'(sal), 8'hA5);
        chk("single_canal", int'(canal), 2);

        // drain: valid drops, word held
        cycle(1'b0, 5'b00000, e, 1'b1);
        chk("drain_valid", int'(sal_valida), 0);
        chk("drain_sal", int'(sal), 8'hA5);

        // backpressure
        e = 40'h5E_4D_3C_2B_1A;
        cycle(1'b0, 5'b00100, e, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 5'b00011, e, 1'b0);
            chk("bp_sal", int'(sal), 8'h3C);
            chk("bp_canal", int'(canal), 2);
        end
        cycle(1'b0, 5'b00011, e, 1'b1);
        chk("bp_release_canal", int'(canal), 0);
        chk("bp_release_sal", int'(sal), 8'h1A);
        chk("bp_release_valid", int'(sal_valida), 1);

        // all channels requesting continuously
        cycle(1'b1, 5'b00000, e, 1'b1);
`ifdef SELECTOR_ARB_RR_EN
        rr_exp = '{0, 1, 2, 3, 4, 0};
`else
        rr_exp = '{0, 0, 0, 0, 0, 0};
`endif
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 5'b11111, e, 1'b1);
            chk("rr_canal", int'(canal), rr_exp[i]);
        end

        // reset while holding a stalled word
        cycle(1'b0, 5'b00010, e, 1'b0);
        cycle(1'b0, 5'b00010, e, 1'b0);
        cycle(1'b1, 5'b00010, e, 1'b0);
        chk("midrst_valid", int'(sal_valida), 0);
        cycle(1'b0, 5'b10001, e, 1'b1);
        chk("post_rst_canal", int'(canal), 0);
        chk("post_rst_sal", int'(sal), 8'h1A);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            e = {$urandom(), $urandom()};
            cycle(($urandom_range(0, 39) == 0), 5'($urandom()), e, ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
